// File: rtl/divu_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package divu_pkg;

  // Default operand/result width in bits.
  localparam int DIV_WIDTH = 32;

  // Width of the step counter for the default width (counts WIDTH-1 down to 0).
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Quotient reported for a zero divisor: all ones.
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  // Controller states.
  typedef enum logic [1:0] {
    DIVU_IDLE = 2'd0,
    DIVU_RUN  = 2'd1,
    DIVU_DONE = 2'd2
  } divu_state_e;

endpackage

// File: rtl/divu_iterative_step.sv
// One restoring shift-compare-subtract step. Purely combinational, so two
// copies can be chained later for two quotient bits per clock.
module divu_iterative_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             ge_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift the next dividend bit in, trial-subtract, keep the difference only
  // when there was no borrow (partial remainder not less than divisor).
  always_comb begin
    shifted = {rem_i, quo_msb_i};
    diff    = shifted - {1'b0, div_i};
    ge_o    = ~diff[WIDTH];
    rem_o   = ge_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divu_iterative.sv
// Multi-cycle unsigned divider: one quotient bit per clock, start/busy/done
// handshake, results held in output registers until the next completion.
//
// Handshake: iStart is sampled only while oBusy is low (IDLE or DONE); the
// sampling edge also captures iDataA/iDataB. oBusy is high for exactly the
// WIDTH step cycles, oDone is a one-cycle pulse with results valid, and the
// two are never high together. A request in the DONE cycle is accepted
// directly so back-to-back divisions have no idle bubble.
module divu_iterative
  import divu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDataA,
  input  logic [WIDTH-1:0] iDataB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero,
  output logic [1:0]       oDbgState
);

  localparam int CNT_W = $clog2(WIDTH);

  divu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_ge;

  divu_iterative_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_msb_i (quo_q[WIDTH-1]),
    .div_i     (div_q),
    .rem_o     (step_rem),
    .ge_o      (step_ge)
  );

  // State, counter, working datapath and result registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= DIVU_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      div0_q    <= div0_d;
    end
  end

  // Next-state and datapath updates; result registers move only on the edge
  // that enters DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    div0_d    = div0_q;

    case (state_q)
      DIVU_IDLE, DIVU_DONE: begin
        if (iStart) begin
          if (iDataB != '0) begin
            state_d = DIVU_RUN;
            rem_d   = '0;
            quo_d   = iDataA;
            div_d   = iDataB;
            cnt_d   = CNT_W'(WIDTH - 1);
          end else begin
            // Zero divisor completes immediately without any steps.
            state_d   = DIVU_DONE;
            res_quo_d = {WIDTH{DIV0_QUOTIENT[0]}};
            res_rem_d = iDataA;
            div0_d    = 1'b1;
          end
        end else if (state_q == DIVU_DONE) begin
          state_d = DIVU_IDLE;
        end
      end

      DIVU_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_ge};
        if (cnt_q == '0) begin
          state_d   = DIVU_DONE;
          res_quo_d = {quo_q[WIDTH-2:0], step_ge};
          res_rem_d = step_rem;
          div0_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = DIVU_IDLE;
      end
    endcase
  end

  // Handshake and result outputs are straight decodes of registers.
  always_comb begin
    oBusy      = (state_q == DIVU_RUN);
    oDone      = (state_q == DIVU_DONE);
    oQuotient  = res_quo_q;
    oRemainder = res_rem_q;
    oDivByZero = div0_q;
    oDbgState  = state_q;
  end

endmodule

// File: tb/tb_divu_iterative.sv
// Bench for divu_iterative: directed cases plus randomized operands checked
// against plain integer division, with a done-side scoreboard.
module tb_divu_iterative;

  localparam int W = 32;

  logic         iClk;
  logic         iRstN;
  logic         iStart;
  logic [W-1:0] iDataA;
  logic [W-1:0] iDataB;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oQuotient;
  logic [W-1:0] oRemainder;
  logic         oDivByZero;
  logic [1:0]   oDbgState;

  divu_iterative #(.WIDTH(W)) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iStart     (iStart),
    .iDataA     (iDataA),
    .iDataB     (iDataB),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivByZero (oDivByZero),
    .oDbgState  (oDbgState)
  );

  // ---------------- clock / reset ----------------
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_z_q[$];
  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: ordinary unsigned division; zero divisor gives all-ones / dividend.
  task automatic model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z);
    if (b == 0) begin
      q = {W{1'b1}};
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Monitor: results at every oDone, mutual exclusion, results held while busy.
  always @(negedge iClk) begin
    if (iRstN) begin
      check("done_busy_excl", 64'(oDone & oBusy), 64'd0);
      if (oBusy) begin
        check("hold_quotient", 64'(oQuotient), 64'(last_q));
        check("hold_remainder", 64'(oRemainder), 64'(last_r));
      end
      if (oDone) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [W-1:0] eq, er, ea, eb;
          logic         ez;
          eq = exp_q.pop_front();
          er = exp_r_q.pop_front();
          ez = exp_z_q.pop_front();
          ea = a_q.pop_front();
          eb = b_q.pop_front();
          check("quotient", 64'(oQuotient), 64'(eq));
          check("remainder", 64'(oRemainder), 64'(er));
          check("div_by_zero", 64'(oDivByZero), 64'(ez));
          if (eb != 0) begin
            check("invariant_qb_r", 64'(oQuotient) * 64'(eb) + 64'(oRemainder), 64'(ea));
            check("rem_lt_div", 64'(oRemainder < eb), 64'd1);
          end
          last_q = eq;
          last_r = er;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; issues one request and returns at the negedge where
  // oDone is seen. inj_cyc > 0 pulses a 9/9 request during that busy cycle.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_cyc);
    logic [W-1:0] q, r;
    logic         z;
    int           k, busy_n;
    bit           seen;
    model_div(a, b, q, r, z);
    exp_q.push_back(q);
    exp_r_q.push_back(r);
    exp_z_q.push_back(z);
    a_q.push_back(a);
    b_q.push_back(b);
    iStart = 1'b1;
    iDataA = a;
    iDataB = b;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    iDataA = $urandom;
    iDataB = $urandom;
    k      = 0;
    busy_n = 0;
    seen   = 0;
    while (!seen && k < 100) begin
      @(negedge iClk);
      k++;
      if (k == inj_cyc) begin
        iStart = 1'b1;
        iDataA = 32'd9;
        iDataB = 32'd9;
      end else begin
        iStart = 1'b0;
      end
      if (oBusy) busy_n++;
      if (oDone) seen = 1;
    end
    iStart = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(k - 1), (b == 0) ? 64'd0 : 64'(W));
    check("busy_cycles", 64'(busy_n), (b == 0) ? 64'd0 : 64'(W));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(oBusy), 64'd0);
    check({tag, "_done"}, 64'(oDone), 64'd0);
    check({tag, "_quotient"}, 64'(oQuotient), 64'd0);
    check({tag, "_remainder"}, 64'(oRemainder), 64'd0);
    check({tag, "_div0"}, 64'(oDivByZero), 64'd0);
    check({tag, "_state"}, 64'(oDbgState), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    int           mode;

    iRstN  = 1'b0;
    iStart = 1'b0;
    iDataA = '0;
    iDataB = '0;
    repeat (3) @(negedge iClk);
    check_all_zero("reset");
    iRstN = 1'b1;
    @(negedge iClk);
    check_all_zero("post_reset");

    // Basic cases.
    run_div(32'd100, 32'd7, 0);
    check("dir_100_7_q", 64'(oQuotient), 64'd14);
    check("dir_100_7_r", 64'(oRemainder), 64'd2);
    check("dir_100_7_z", 64'(oDivByZero), 64'd0);
    @(negedge iClk);
    check("done_is_one_cycle", 64'(oDone), 64'd0);

    run_div(32'd3, 32'd10, 0);
    check("dir_3_10_q", 64'(oQuotient), 64'd0);
    check("dir_3_10_r", 64'(oRemainder), 64'd3);

    run_div(32'hFFFF_FFFF, 32'd1, 0);
    check("dir_ones_1_q", 64'(oQuotient), 64'hFFFF_FFFF);
    check("dir_ones_1_r", 64'(oRemainder), 64'd0);

    // Zero divisor.
    @(negedge iClk);
    run_div(32'd5, 32'd0, 0);
    check("dir_5_0_q", 64'(oQuotient), 64'hFFFF_FFFF);
    check("dir_5_0_r", 64'(oRemainder), 64'd5);
    check("dir_5_0_z", 64'(oDivByZero), 64'd1);
    repeat (3) @(negedge iClk);
    check("idle_hold_q", 64'(oQuotient), 64'hFFFF_FFFF);
    check("idle_hold_z", 64'(oDivByZero), 64'd1);
    check("idle_state", 64'(oDbgState), 64'd0);

    // Request during RUN is ignored; request in DONE is accepted back-to-back.
    run_div(32'd1000, 32'd3, 10);
    check("dir_1000_3_q", 64'(oQuotient), 64'd333);
    check("dir_1000_3_r", 64'(oRemainder), 64'd1);
    run_div(32'd9, 32'd9, 0);
    check("dir_9_9_q", 64'(oQuotient), 64'd1);
    check("dir_9_9_r", 64'(oRemainder), 64'd0);

    // Reset in the middle of a run aborts it with no completion.
    @(negedge iClk);
    iStart = 1'b1;
    iDataA = 32'd1000;
    iDataB = 32'd3;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (15) @(negedge iClk);
    check("midrun_busy", 64'(oBusy), 64'd1);
    iRstN = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    last_q = '0;
    last_r = '0;
    repeat (2) @(negedge iClk);
    iRstN = 1'b1;
    repeat (40) @(negedge iClk);
    check("no_done_after_abort", 64'(oDone), 64'd0);
    run_div(32'd50, 32'd5, 0);
    check("dir_50_5_q", 64'(oQuotient), 64'd10);
    check("dir_50_5_r", 64'(oRemainder), 64'd0);

    // Randomized operands with emphasis on the edge classes.
    for (int n = 0; n < 1500; n++) begin
      mode = $urandom_range(0, 7);
      case (mode)
        0: begin ra = $urandom; rb = 32'd1; end
        1: begin ra = $urandom_range(0, 1000); rb = ra + 32'd1 + $urandom_range(0, 1000); end
        2: begin ra = 32'hFFFF_FFFF; rb = $urandom; end
        3: begin ra = $urandom; rb = 32'hFFFF_FFFF; end
        4: begin ra = $urandom; rb = 32'd0; end
        5: begin ra = $urandom; rb = $urandom_range(1, 16); end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      run_div(ra, rb, 0);
      repeat ($urandom_range(0, 2)) @(negedge iClk);
    end

    repeat (3) @(negedge iClk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
